truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential exerciser for the team's small gate-level combinational functions (e.g. NAND-only ~a | b).
- Drives every input vector of an N-input, 1-output function in ascending order and waits a fixed settle time per vector.
- Samples the function's output, builds the captured truth table and checks it against an expected table.
- Sits on the other side of the function's interface: it generates the inputs and reads back the output.

Parameters:
- N_IN, 2, number of function inputs (1..6).
- SETTLE, 2, cycles a vector is held before sampling (>=1).
- EXPECTED, 4'b1011, expected truth table, width 2**N_IN; bit i = expected output for vec == i. The default is ~a | b with vec = {a,b}.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a sweep; sampled only in IDLE.
- s  input  1  output of the function under test.
- vec  output  N_IN  input vector driven to the function; vec[N_IN-1] = a, vec[0] = last input.
- busy  output  1  high from the cycle after start is accepted until FIN inclusive.
- done  output  1  one-cycle pulse in FIN.
- pass  output  1  1 when the last completed sweep had no mismatches.
- table  output  2**N_IN  captured truth table.
- err_cnt  output  N_IN+1  mismatch count of the current or last sweep.
- first_err  output  N_IN  index of the first mismatch; valid only when err_cnt != 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - vec, busy, done, pass, table, err_cnt, first_err all 0.
  - Internal settle counter 0.
  - Takes effect immediately, including mid-sweep; no done pulse is issued for an aborted sweep.
- States: IDLE, WAIT, SAMPLE, FIN. All outputs are registered.
- IDLE, start=1 at an edge:
  - vec<=0, table<=0, err_cnt<=0, first_err<=0, pass<=0.
  - busy<=1, counter<=SETTLE, state<=WAIT.
  - With start=0: hold all outputs, so results persist until the next sweep.
- WAIT: counter decrements each cycle. When counter==1 -> SAMPLE. WAIT therefore lasts exactly SETTLE cycles.
- SAMPLE (one cycle), with s sampled at the closing edge:
  - table[vec]<=s.
  - If s != EXPECTED[vec]: err_cnt<=err_cnt+1, and first_err<=vec if err_cnt==0.
  - If vec == 2**N_IN-1: state<=FIN. vec is not incremented; there is no wrap-around.
  - Otherwise: vec<=vec+1, counter<=SETTLE, state<=WAIT.
- FIN (one cycle):
  - done=1, busy=1.
  - pass<=(err_cnt==0), using the final count including the last sample.
  - Next state IDLE with busy<=0, done<=0, vec<=0.
- start is ignored in WAIT, SAMPLE and FIN. If start is held high, a new sweep is accepted in the first IDLE cycle after FIN.
- Latency: the start edge is cycle 0. The last sample is at cycle 2**N_IN*(SETTLE+1), and done is high in cycle 2**N_IN*(SETTLE+1)+1. With the defaults, done is high in cycle 13.
- err_cnt saturates naturally: the maximum is 2**N_IN, which fits in N_IN+1 bits.
- The RTL does no X handling; the bench must drive known values on s.

Test Plan:
1. Defaults; s driven by the team's NAND-only ~a | b gate (a=vec[1], b=vec[0]); one-cycle start pulse -> vec steps 0,1,2,3 every 3 cycles; done high in cycle 13 only; table=4'b1011, err_cnt=0, pass=1.
2. Defaults; s = a & b -> table=4'b1000, err_cnt=2, first_err=0, pass=0; outputs hold after done until the next start.
3. start held high for 40 cycles -> sweeps back to back; each done is followed by exactly one IDLE cycle (busy=0) and then busy=1; start pulses during WAIT/SAMPLE change nothing.
4. rst_n pulsed low in cycle 5 of a sweep (mid-WAIT, vec=1) -> all outputs 0 asynchronously with no done; a new start afterwards gives the full correct result of scenario 1.
5. N_IN=3, SETTLE=1, EXPECTED=8'b11101000, s = 3-input majority -> done in cycle 17, table=8'b11101000, pass=1; majority inverted -> err_cnt=8, first_err=0.
6. SETTLE=2, s = function output delayed by one register stage -> still pass=1; same setup with SETTLE=1 and two register stages -> pass=0, err_cnt nonzero.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps all input vectors of an N-input function and checks its truth table
module truth_table_sweeper #(
    parameter int N_IN = 2,
    parameter int SETTLE = 2,
    parameter logic [(1 << N_IN)-1:0] EXPECTED = 4'b1011
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   s_i,
    output logic [N_IN-1:0]        vec_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic [(1 << N_IN)-1:0] table_o,
    output logic [N_IN:0]          err_cnt_o,
    output logic [N_IN-1:0]        first_err_o
);
    localparam int NV = 1 << N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);
    localparam logic [CW-1:0] SETTLE_CNT = CW'(SETTLE);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_FIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [NV-1:0]   table_q, table_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ferr_q, ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            table_q <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            table_q <= table_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        table_d = table_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    vec_d   = '0;
                    table_d = '0;
                    err_d   = '0;
                    ferr_d  = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = SETTLE_CNT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                table_d[vec_q] = s_i;
                if (s_i != EXPECTED[vec_q]) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) ferr_d = vec_q;
                end
                // The last vector holds until FIN so vec never wraps mid-sweep.
                if (vec_q == LAST_VEC) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = SETTLE_CNT;
                    state_d = S_WAIT;
                end
            end
            S_FIN: begin
                pass_d  = (err_q == '0);
                busy_d  = 1'b0;
                vec_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign vec_o       = vec_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign table_o     = table_q;
    assign err_cnt_o   = err_q;
    assign first_err_o = ferr_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - randomized self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_a_n;
    int checks = 0;
    int failures = 0;

    logic [63:0] tt_v [3];
    int          mode_a;
    logic        start_a, start_b, start_c;

    // Instance A: defaults; s from NAND gate, table lookup, or one register stage
    logic [1:0] vec_a; logic busy_a, done_a, pass_a, s_a, reg_a, nand_out;
    logic [3:0] table_a; logic [2:0] err_a; logic [1:0] ferr_a;
    assign nand_out = ~(vec_a[1] & ~(vec_a[0] & vec_a[0]));
    always @(posedge clk) reg_a <= tt_v[0][vec_a];
    assign s_a = (mode_a == 0) ? nand_out : (mode_a == 1) ? tt_v[0][vec_a] : reg_a;

    truth_table_sweeper u_a (
        .clk(clk), .rst_n(rst_a_n), .start_i(start_a), .s_i(s_a), .vec_o(vec_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .table_o(table_a),
        .err_cnt_o(err_a), .first_err_o(ferr_a));

    // Instance B: 3 inputs, SETTLE=1, majority expected
    logic [2:0] vec_b; logic busy_b, done_b, pass_b, s_b;
    logic [7:0] table_b; logic [3:0] err_b; logic [2:0] ferr_b;
    assign s_b = tt_v[1][vec_b];

    truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECTED(8'b11101000)) u_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .s_i(s_b), .vec_o(vec_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .table_o(table_b),
        .err_cnt_o(err_b), .first_err_o(ferr_b));

    // Instance C: SETTLE=1 with the function seen through two register stages
    logic [1:0] vec_c; logic busy_c, done_c, pass_c, r1_c, r2_c;
    logic [3:0] table_c; logic [2:0] err_c; logic [1:0] ferr_c;
    always @(posedge clk) begin
        r1_c <= tt_v[2][vec_c];
        r2_c <= r1_c;
    end

    truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECTED(4'b1011)) u_c (
        .clk(clk), .rst_n(rst_n), .start_i(start_c), .s_i(r2_c), .vec_o(vec_c),
        .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c), .table_o(table_c),
        .err_cnt_o(err_c), .first_err_o(ferr_c));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] get(input int inst, input int which);
        logic [63:0] r;
        r = '0;
        case (inst)
            0: case (which) 0: r = 64'(vec_a); 1: r = 64'(busy_a); 2: r = 64'(done_a); 3: r = 64'(pass_a);
                            4: r = 64'(table_a); 5: r = 64'(err_a); default: r = 64'(ferr_a); endcase
            1: case (which) 0: r = 64'(vec_b); 1: r = 64'(busy_b); 2: r = 64'(done_b); 3: r = 64'(pass_b);
                            4: r = 64'(table_b); 5: r = 64'(err_b); default: r = 64'(ferr_b); endcase
            default: case (which) 0: r = 64'(vec_c); 1: r = 64'(busy_c); 2: r = 64'(done_c); 3: r = 64'(pass_c);
                            4: r = 64'(table_c); 5: r = 64'(err_c); default: r = 64'(ferr_c); endcase
        endcase
        return r;
    endfunction

    task automatic set_start(input int inst, input logic v);
        case (inst)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    // One full sweep; lag = how many vectors the sampled output trails the driven vector
    task automatic sweep(input int inst, input int mode, input logic [63:0] tt, input int lag,
                         input bit noise, input string name);
        int n, st, nv, L, j, exp_err, exp_ferr, evec;
        logic [63:0] exp_tab, expct;
        n = (inst == 1) ? 3 : 2;
        st = (inst == 0) ? 2 : 1;
        expct = (inst == 1) ? 64'hE8 : 64'hB;
        nv = 1 << n;
        L = nv * (st + 1);
        tt_v[inst] = tt;
        if (inst == 0) mode_a = mode;
        exp_tab = '0; exp_err = 0; exp_ferr = 0;
        for (int i = 0; i < nv; i++) begin
            j = (i - lag < 0) ? 0 : i - lag;
            exp_tab[i] = tt[j];
            if (tt[j] != expct[i]) begin
                if (exp_err == 0) exp_ferr = i;
                exp_err++;
            end
        end
        repeat (3) @(negedge clk);
        set_start(inst, 1'b1);
        @(posedge clk);
        #1 set_start(inst, noise ? 1'($urandom) : 1'b0);
        for (int c = 1; c <= L + 3; c++) begin
            @(posedge clk);
            #1;
            evec = (c < L) ? c / (st + 1) : (c == L) ? nv - 1 : 0;
            check($sformatf("%s vec c%0d", name, c), get(inst, 0), 64'(evec));
            check($sformatf("%s busy c%0d", name, c), get(inst, 1), 64'(c <= L));
            check($sformatf("%s done c%0d", name, c), get(inst, 2), 64'(c == L));
            set_start(inst, (noise && c <= L) ? 1'($urandom) : 1'b0);
        end
        check({name, " table"}, get(inst, 4), exp_tab);
        check({name, " err_cnt"}, get(inst, 5), 64'(exp_err));
        check({name, " pass"}, get(inst, 3), 64'(exp_err == 0));
        if (exp_err != 0) check({name, " first_err"}, get(inst, 6), 64'(exp_ferr));
    endtask

    initial begin
        logic [63:0] maj;
        int pd1, pd2, ndone, tmo;
        bit saw_done;
        rst_n = 1'b0; rst_a_n = 1'b0;
        start_a = 0; start_b = 0; start_c = 0;
        mode_a = 0;
        for (int k = 0; k < 3; k++) tt_v[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 7; w++) check($sformatf("reset out%0d", w), get(0, w), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; rst_a_n = 1'b1;

        sweep(0, 0, 64'hB, 0, 0, "nand");
        sweep(0, 1, 64'h8, 0, 0, "and");
        repeat (10) @(posedge clk);
        #1;
        check("hold table", get(0, 4), 64'h8);
        check("hold err", get(0, 5), 64'd2);
        check("hold pass", get(0, 3), 64'd0);
        check("hold busy", get(0, 1), 64'd0);

        // Back-to-back sweeps with start held high: 14-cycle period
        mode_a = 0;
        @(negedge clk);
        start_a = 1'b1;
        pd1 = 0; pd2 = 0; ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b done c%0d", c), 64'(done_a), 64'((c % 14) == 12));
            if (pd1 != 0) check($sformatf("b2b idle c%0d", c), 64'(busy_a), 64'd0);
            if (pd2 != 0) check($sformatf("b2b rebusy c%0d", c), 64'(busy_a), 64'd1);
            pd2 = pd1; pd1 = int'(done_a);
            if (done_a) ndone++;
        end
        start_a = 1'b0;
        check("b2b ndone", 64'(ndone), 64'd2);
        tmo = 0;
        while (busy_a && tmo < 50) begin
            @(posedge clk);
            #1;
            tmo++;
        end
        check("b2b drain", 64'(busy_a), 64'd0);
        check("b2b table", 64'(table_a), 64'hB);

        // Asynchronous reset mid-WAIT
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("abort vec before", 64'(vec_a), 64'd1);
        #2 rst_a_n = 1'b0;
        #1;
        for (int w = 0; w < 7; w++) check($sformatf("abort out%0d", w), get(0, w), 64'd0);
        @(negedge clk);
        rst_a_n = 1'b1;
        saw_done = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (done_a) saw_done = 1;
        end
        check("abort no done", 64'(saw_done), 64'd0);
        sweep(0, 0, 64'hB, 0, 0, "after_rst");

        // 3-input majority
        maj = '0;
        for (int i = 0; i < 8; i++) maj[i] = ($countones(i) >= 2);
        sweep(1, 0, maj, 0, 1, "maj");
        sweep(1, 0, ~maj & 64'hFF, 0, 0, "maj_inv");
        check("maj_inv err8", 64'(err_b), 64'd8);

        // Register-delayed function outputs
        sweep(0, 2, 64'hB, 0, 1, "delay1");
        sweep(2, 0, 64'hB, 1, 0, "delay2");

        // Random truth tables
        for (int k = 0; k < 5; k++) begin
            sweep(0, 1, 64'($urandom_range(0, 15)), 0, 1, $sformatf("rndA%0d", k));
            sweep(1, 0, 64'($urandom_range(0, 255)), 0, 1, $sformatf("rndB%0d", k));
            sweep(2, 0, 64'($urandom_range(0, 15)), 1, 1, $sformatf("rndC%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
